mips_mmio_timer: RTL and testbench
==================================

Name: mips_mmio_timer

Overview:
- Memory-mapped I/O peripheral that sits directly downstream of the single-cycle MIPS core's data-memory port, alongside data memory.
- Decodes LW/SW accesses that fall in its address window.
- Provides an LED output register, a synchronized switch input, and a prescaled 32-bit timer with compare match, a sticky flag and an interrupt line.
- Reads are combinational, so LW completes in the core's single cycle; writes commit on the rising clock edge.

Parameters:
- BASE_ADDR, 32'h0000_FF00, word-aligned base of the 32-byte register window.
- PRESCALE, 100, clock cycles per timer tick (1 us at 100 MHz); legal range 1..65535.
- SW_WIDTH, 16, number of switch inputs.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_addr  in  32  byte address from the ALU result
- mem_wdata  in  32  store data (Reg[rt])
- mem_wr  in  1  store strobe (MemWr)
- mem_rd  in  1  load strobe (MemToReg)
- sw  in  SW_WIDTH  asynchronous switch inputs
- hit  out  1  access decodes into this window; the core muxes rdata over data memory when hit=1
- rdata  out  32  combinational read data
- led  out  16  LED register contents
- irq  out  1  interrupt request

Behaviour:
- Decode: hit = (mem_rd | mem_wr) & (mem_addr[31:5] == BASE_ADDR[31:5]) & (mem_addr[1:0] == 2'b00).
  - Misaligned accesses give hit=0 and are ignored.
  - hit is combinational.
- Register map (offset = mem_addr[4:2]):
  - 0 LED: RW; bits [15:0] stored, upper bits read 0.
  - 1 SW: RO; 2-flop synchronized sw, zero-extended. The value seen is the pin state from 2 cycles earlier.
  - 2 CNT: RW, 32-bit timer count.
  - 3 CMP: RW, 32-bit compare value.
  - 4 STATUS: bit0 MATCH, sticky; writing 1 to bit0 clears it.
  - 5 CTRL: RW, bits [2:0] only.
    - bit0 EN: timer runs.
    - bit1 CLR_ON_MATCH: CNT reloads to 0 on match.
    - bit2 IRQ_EN.
  - 6, 7: read 0, writes ignored.
- rdata = selected register when hit & mem_rd, else 32'h0.
- Writes take effect only when hit & mem_wr at a rising edge. Writes to read-only fields are ignored.
- Prescaler:
  - 16-bit counter, runs only while EN=1.
  - Counts 0..PRESCALE-1, then wraps to 0 and asserts the one-cycle internal tick on the wrap cycle.
  - Reset to 0 whenever EN=0.
- Timer tick:
  - If CNT == CMP: MATCH <= 1. If CLR_ON_MATCH=1, CNT <= 0; otherwise CNT <= CNT+1.
  - Otherwise CNT <= CNT+1.
  - CNT wraps from 32'hFFFF_FFFF to 0 with no flag.
- Simultaneous events:
  - CPU write to CNT and a tick in the same cycle: the write wins and the tick is lost.
  - A match set and a W1C clear of MATCH in the same cycle: the set wins and MATCH stays 1.
  - CPU write to CMP takes effect for compares from the next cycle.
- irq = MATCH & IRQ_EN, registered-free (combinational from state).
- Reset (async, rst=1):
  - All registers 0: led=0, CNT=0, CMP=0, STATUS=0, CTRL=0, prescaler=0, sync flops=0.
  - Hence irq=0. rdata=0 and hit=0 when no access is presented.
  - Reset asserted mid-count clears immediately, without waiting for a clock edge. Counting resumes only after software sets EN.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-run with EN=1 and CNT=0x1234.
  - Required: led, CNT and irq go to 0 before the next edge; after rst falls, CNT holds 0 until EN is written.
- LED and decode:
  - Stimulus: SW 0xDEADBEEF to BASE+0x00.
  - Required: led=0xBEEF next cycle; LW BASE+0x00 returns 0x0000BEEF.
  - Stimulus: SW to BASE+0x02 (misaligned) and to BASE+0x20 (outside window).
  - Required: hit=0, led unchanged.
- Timer match:
  - Stimulus: PRESCALE=4, CMP=3, CTRL=0x7.
  - Required: first match tick 16 cycles after EN; MATCH=1 and irq=1; CNT reads 0 right after the match.
  - Stimulus: W1C STATUS with 0x1.
  - Required: irq=0.
- Free-run wrap:
  - Stimulus: write CNT=0xFFFFFFFF, CTRL=0x1, CMP=5.
  - Required: one tick later CNT=0 with MATCH=0; MATCH sets on the tick where CNT==5, and CNT goes to 6 because CLR_ON_MATCH=0.
- Collisions:
  - Stimulus: write CNT=0x100 on a tick cycle.
  - Required: CNT=0x100, not 0x101.
  - Stimulus: W1C STATUS on a match cycle.
  - Required: MATCH remains 1.
- Switch sync:
  - Stimulus: toggle sw to 0xA5A5.
  - Required: LW BASE+0x04 returns the old value for 2 cycles, then 0x0000A5A5.

Source files
------------

// File: rtl/mips_mmio_timer.sv
// rtl/mips_mmio_timer.sv - MMIO LED/switch/timer peripheral on the MIPS data-memory port
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   mem_addr   byte address from the core ALU result
//   mem_wdata  store data
//   mem_wr     store strobe
//   mem_rd     load strobe
//   sw         asynchronous switch inputs (SW_WIDTH bits)
//   hit        access decodes into this register window
//   rdata      combinational read data (0 unless hit & mem_rd)
//   led        LED register contents
//   irq        MATCH & IRQ_EN
//
// Register map (word offset = mem_addr[4:2]):
//   0 LED (RW, [15:0])   1 SW (RO, synchronized)   2 CNT (RW)   3 CMP (RW)
//   4 STATUS (bit0 MATCH, W1C)   5 CTRL (RW, [2:0] = IRQ_EN, CLR_ON_MATCH, EN)
//   6,7 read 0, writes ignored

module mips_mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter int          PRESCALE  = 100,
    parameter int          SW_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic                mem_wr,
    input  logic                mem_rd,
    input  logic [SW_WIDTH-1:0] sw,
    output logic                hit,
    output logic [31:0]         rdata,
    output logic [15:0]         led,
    output logic                irq
);

    localparam logic [2:0]  OFF_LED    = 3'd0;
    localparam logic [2:0]  OFF_SW     = 3'd1;
    localparam logic [2:0]  OFF_CNT    = 3'd2;
    localparam logic [2:0]  OFF_CMP    = 3'd3;
    localparam logic [2:0]  OFF_STATUS = 3'd4;
    localparam logic [2:0]  OFF_CTRL   = 3'd5;
    localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);

    logic [15:0]         r_led;
    logic [SW_WIDTH-1:0] r_sw_meta;
    logic [SW_WIDTH-1:0] r_sw_sync;
    logic [31:0]         r_cnt;
    logic [31:0]         r_cmp;
    logic                r_match;
    logic [2:0]          r_ctrl;
    logic [15:0]         r_pre;

    logic                w_hit;
    logic                w_wr;
    logic                w_rd;
    logic [2:0]          w_off;
    logic                w_en;
    logic                w_clr_on_match;
    logic                w_irq_en;
    logic                w_tick;
    logic                w_match_evt;
    logic [31:0]         w_rdata;

    // Address decode: word-aligned accesses inside the 32-byte window only.
    assign w_hit = (mem_rd | mem_wr)
                 & (mem_addr[31:5] == BASE_ADDR[31:5])
                 & (mem_addr[1:0] == 2'b00);
    assign w_wr  = w_hit & mem_wr;
    assign w_rd  = w_hit & mem_rd;
    assign w_off = mem_addr[4:2];

    assign w_en           = r_ctrl[0];
    assign w_clr_on_match = r_ctrl[1];
    assign w_irq_en       = r_ctrl[2];

    // One-cycle tick on the prescaler wrap cycle; only while EN is set.
    assign w_tick      = w_en & (r_pre == PRE_LAST);
    assign w_match_evt = w_tick & (r_cnt == r_cmp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= 16'd0;
        end else if (!w_en || w_tick) begin
            r_pre <= 16'd0;
        end else begin
            r_pre <= r_pre + 16'd1;
        end
    end

    // A CPU write to CNT overrides a coincident tick; that tick is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 32'd0;
        end else if (w_wr && (w_off == OFF_CNT)) begin
            r_cnt <= mem_wdata;
        end else if (w_tick) begin
            if (w_match_evt && w_clr_on_match) begin
                r_cnt <= 32'd0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    // Setting MATCH takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match <= 1'b0;
        end else if (w_match_evt) begin
            r_match <= 1'b1;
        end else if (w_wr && (w_off == OFF_STATUS) && mem_wdata[0]) begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led  <= 16'd0;
            r_cmp  <= 32'd0;
            r_ctrl <= 3'd0;
        end else if (w_wr) begin
            if (w_off == OFF_LED) begin
                r_led <= mem_wdata[15:0];
            end
            if (w_off == OFF_CMP) begin
                r_cmp <= mem_wdata;
            end
            if (w_off == OFF_CTRL) begin
                r_ctrl <= mem_wdata[2:0];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switch pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            case (w_off)
                OFF_LED:    w_rdata = {16'd0, r_led};
                OFF_SW:     w_rdata = 32'(r_sw_sync);
                OFF_CNT:    w_rdata = r_cnt;
                OFF_CMP:    w_rdata = r_cmp;
                OFF_STATUS: w_rdata = {31'd0, r_match};
                OFF_CTRL:   w_rdata = {29'd0, r_ctrl};
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    assign hit   = w_hit;
    assign rdata = w_rdata;
    assign led   = r_led;
    assign irq   = r_match & w_irq_en;

endmodule

// File: tb/tb_mips_mmio_timer.sv
// tb/tb_mips_mmio_timer.sv - randomized self-checking bench for mips_mmio_timer

module tb_mips_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_FF00;
    localparam int          P    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic [15:0] sw = 16'd0;
    logic        hit;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        irq;

    mips_mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(P), .SW_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .sw(sw), .hit(hit), .rdata(rdata),
        .led(led), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] m_led;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_match;
    logic [2:0]  m_ctrl;
    int          m_run;
    logic [15:0] m_s1;
    logic [15:0] m_s2;

    logic [15:0] sw_drive = 16'd0;
    logic [31:0] last_rdata;
    logic        last_hit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_led = 16'd0; m_cnt = 32'd0; m_cmp = 32'd0; m_match = 1'b0;
        m_ctrl = 3'd0; m_run = 0; m_s1 = 16'd0; m_s2 = 16'd0;
    endtask

    function automatic logic m_hit(input logic [31:0] a, input logic w, input logic r);
        return (w | r) && ((a >> 5) == (BASE >> 5)) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic w, input logic r);
        if (!(m_hit(a, w, r) && r)) return 32'd0;
        case (a[4:2])
            3'd0: return {16'd0, m_led};
            3'd1: return {16'd0, m_s2};
            3'd2: return m_cnt;
            3'd3: return m_cmp;
            3'd4: return {31'd0, m_match};
            3'd5: return {29'd0, m_ctrl};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic tick_next();
        return m_ctrl[0] && ((m_run % P) == P - 1);
    endfunction

    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input logic r, input logic [15:0] pin);
        logic we, tick, evt;
        logic [2:0] off;
        we   = m_hit(a, w, r) && w;
        off  = a[4:2];
        tick = tick_next();
        evt  = tick && (m_cnt == m_cmp);
        m_run = m_ctrl[0] ? m_run + 1 : 0;
        if (tick) m_cnt = (evt && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
        if (we && off == 3'd0) m_led = d[15:0];
        if (we && off == 3'd2) m_cnt = d;
        if (we && off == 3'd3) m_cmp = d;
        if (we && off == 3'd5) m_ctrl = d[2:0];
        if (we && off == 3'd4 && d[0]) m_match = 1'b0;
        if (evt) m_match = 1'b1;
        m_s2 = m_s1;
        m_s1 = pin;
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        @(negedge clk);
        mem_addr = a; mem_wdata = d; mem_wr = w; mem_rd = r; sw = sw_drive;
        #1;
        check_eq("hit", {31'd0, hit}, {31'd0, m_hit(a, w, r)});
        check_eq("rdata", rdata, m_read(a, w, r));
        check_eq("led", {16'd0, led}, {16'd0, m_led});
        check_eq("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
        last_rdata = rdata;
        last_hit   = hit;
        @(posedge clk);
        model_step(a, d, w, r, sw_drive);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d);
        bus(BASE + {27'd0, off, 2'b00}, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [2:0] off);
        bus(BASE + {27'd0, off, 2'b00}, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        bus(32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Idle until the next bus cycle is one on which a tick lands.
    task automatic until_tick();
        int k;
        k = 0;
        while (!tick_next() && k < 64) begin
            idle();
            k++;
        end
        if (k >= 64) check_eq("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_hit", {31'd0, hit}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_led", {16'd0, led}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        // LED and decode
        wr(3'd0, 32'hDEADBEEF);
        rd(3'd0);
        check_eq("led_rd", last_rdata, 32'h0000BEEF);
        check_eq("led_pin", {16'd0, led}, 32'h0000BEEF);
        bus(BASE + 32'h2, 32'h1234, 1'b1, 1'b0);
        check_eq("misalign_hit", {31'd0, last_hit}, 32'd0);
        bus(BASE + 32'h20, 32'h5678, 1'b1, 1'b0);
        check_eq("outside_hit", {31'd0, last_hit}, 32'd0);
        rd(3'd0);
        check_eq("led_kept", last_rdata, 32'h0000BEEF);

        // Timer match with clear-on-match
        wr(3'd3, 32'd3);
        wr(3'd5, 32'h7);
        repeat (15) idle();
        rd(3'd4);
        check_eq("match_early", last_rdata, 32'd0);
        rd(3'd4);
        check_eq("match_set", last_rdata, 32'd1);
        check_eq("irq_set", {31'd0, irq}, 32'd1);
        rd(3'd2);
        check_eq("cnt_cleared", last_rdata, 32'd0);
        wr(3'd4, 32'h1);
        idle();
        check_eq("irq_w1c", {31'd0, irq}, 32'd0);

        // Free-run wrap without clear-on-match
        wr(3'd5, 32'h0);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd3, 32'd5);
        wr(3'd4, 32'h1);
        wr(3'd5, 32'h1);
        until_tick();
        idle();
        rd(3'd2);
        check_eq("wrap_cnt", last_rdata, 32'd0);
        rd(3'd4);
        check_eq("wrap_nomatch", last_rdata, 32'd0);
        repeat (6) begin
            until_tick();
            idle();
        end
        rd(3'd4);
        check_eq("free_match", last_rdata, 32'd1);
        rd(3'd2);
        check_eq("free_cnt", last_rdata, 32'd6);

        // Collisions
        until_tick();
        wr(3'd2, 32'h100);
        rd(3'd2);
        check_eq("cnt_write_wins", last_rdata, 32'h100);
        wr(3'd5, 32'h0);
        wr(3'd2, 32'd7);
        wr(3'd3, 32'd7);
        wr(3'd4, 32'h1);
        wr(3'd5, 32'h1);
        until_tick();
        wr(3'd4, 32'h1);
        rd(3'd4);
        check_eq("set_beats_w1c", last_rdata, 32'd1);

        // Switch synchronizer latency
        sw_drive = 16'h1111;
        repeat (3) idle();
        sw_drive = 16'hA5A5;
        rd(3'd1);
        check_eq("sw_old0", last_rdata, 32'h1111);
        rd(3'd1);
        check_eq("sw_old1", last_rdata, 32'h1111);
        rd(3'd1);
        check_eq("sw_new", last_rdata, 32'h0000A5A5);

        // Asynchronous reset mid-count
        wr(3'd5, 32'h5);
        wr(3'd2, 32'h1234);
        wr(3'd3, 32'h1235);
        repeat (5) idle();
        @(negedge clk);
        mem_addr = BASE + 32'h8; mem_wr = 1'b0; mem_rd = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("arst_led", {16'd0, led}, 32'd0);
        check_eq("arst_cnt", rdata, 32'd0);
        check_eq("arst_irq", {31'd0, irq}, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        model_step(mem_addr, mem_wdata, mem_wr, mem_rd, sw_drive);
        repeat (8) rd(3'd2);
        check_eq("arst_cnt_hold", last_rdata, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            logic [2:0]  off;
            logic        w, r;
            off = 3'($urandom_range(0, 7));
            a   = BASE + {27'd0, off, 2'b00};
            case ($urandom_range(0, 15))
                0: a = a + 32'($urandom_range(1, 3));
                1: a = a ^ 32'h20;
                2: a = $urandom;
                default: ;
            endcase
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 1) == 1);
            case (off)
                3'd2, 3'd3: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
                default:    d = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) sw_drive = 16'($urandom);
            bus(a, d, w, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
